// File: rtl/ntt_intt_obi_bridge.sv
// ntt_intt_obi_bridge
// OBI slave that maps a 2 MiB external-slave window onto the packed NTT/INTT
// coefficient memory. Each memory word holds two 12-bit coefficients. On the
// bus side each coefficient sits in its own 16-bit halfword.
//
// Transaction flow: IDLE -> ACCESS -> RESP -> IDLE. Only one transaction is
// outstanding at a time. The response arrives a fixed 2 cycles after the
// grant.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i   OBI request
//   gnt_o/rvalid_o/rdata_o           OBI grant and response
//   engine_busy_i         engine owns the memory; new grants are blocked
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o  memory port
//   mem_rdata_i           memory read data, valid one cycle after a read req
//   err_clr_i, err_o      sticky access-error flag and its clear
//
// Optional feature: define NTT_INTT_BRIDGE_RANGE_CHECK_EN to reject writes in
// which an enabled halfword holds a value >= q (3329).
module ntt_intt_obi_bridge #(
  parameter int WINDOW_BITS = 21,
  parameter int NUM_WORDS   = 128
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic [31:0]                  addr_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  input  logic                         engine_busy_i,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
  output logic [1:0]                   mem_be_o,
  output logic [23:0]                  mem_wdata_o,
  input  logic [23:0]                  mem_rdata_i,
  input  logic                         err_clr_i,
  output logic                         err_o
);

  localparam int IDX_W = WINDOW_BITS - 2;
  localparam int AW    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] NUM_WORDS_IDX = IDX_W'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_reg, state_next;
  logic               we_reg;
  logic [3:0]         be_reg;
  logic [31:0]        wdata_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               err_reg, err_next;

  logic in_range;
  logic drop_write;
  logic access_ok;
  logic err_set;
  logic rd_ok;

  // Reset is folded in so that the grant is also forced low while rst_i is high.
  assign gnt_o = (state_reg == IDLE) && req_i && !engine_busy_i && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      be_reg    <= '0;
      wdata_reg <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (gnt_o) begin
        we_reg    <= we_i;
        be_reg    <= be_i;
        wdata_reg <= wdata_i;
        idx_reg   <= addr_i[WINDOW_BITS-1:2];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_o) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_range = (idx_reg < NUM_WORDS_IDX);

`ifdef NTT_INTT_BRIDGE_RANGE_CHECK_EN
  // Only enabled halfwords are checked; a bad value drops the whole word.
  assign drop_write = we_reg &&
                      (((|be_reg[1:0]) && (wdata_reg[15:0]  >= 16'd3329)) ||
                       ((|be_reg[3:2]) && (wdata_reg[31:16] >= 16'd3329)));
`else
  assign drop_write = 1'b0;
`endif

  assign access_ok = in_range && !drop_write;
  assign err_set   = (state_reg == ACCESS) && !access_ok;
  // If a set and a clear happen in the same cycle, the set wins.
  assign err_next  = err_set || (err_reg && !err_clr_i);
  assign err_o     = err_reg;

  // The memory port is held at zero whenever no request is issued.
  assign mem_req_o   = (state_reg == ACCESS) && access_ok;
  assign mem_we_o    = mem_req_o && we_reg;
  assign mem_addr_o  = mem_req_o ? idx_reg[AW-1:0] : '0;
  assign mem_be_o    = mem_req_o ? {|be_reg[3:2], |be_reg[1:0]} : 2'b00;
  assign mem_wdata_o = mem_req_o ? {wdata_reg[27:16], wdata_reg[11:0]} : 24'h0;

  // The index register is stable through RESP, so the read/error decision can
  // be recomputed there instead of being stored.
  assign rvalid_o = (state_reg == RESP);
  assign rd_ok    = rvalid_o && !we_reg && in_range;
  assign rdata_o  = rd_ok ? {4'h0, mem_rdata_i[23:12], 4'h0, mem_rdata_i[11:0]} : 32'h0;

  // Address bits outside the window and the coefficient padding bits carry no
  // meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:WINDOW_BITS], addr_i[1:0],
                         wdata_reg[31:28], wdata_reg[15:12]};

endmodule

// File: tb/tb_ntt_intt_obi_bridge.sv
module tb_ntt_intt_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        engine_busy_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [6:0]  mem_addr_o;
  logic [1:0]  mem_be_o;
  logic [23:0] mem_wdata_o;
  logic [23:0] mem_rdata_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  ntt_intt_obi_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .engine_busy_i(engine_busy_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .err_clr_i(err_clr_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Coefficient memory model with a one-cycle registered read.
  logic [23:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        if (mem_be_o[0]) mem[mem_addr_o][11:0]  <= mem_wdata_o[11:0];
        if (mem_be_o[1]) mem[mem_addr_o][23:12] <= mem_wdata_o[23:12];
      end else begin
        mem_rdata_i <= mem[mem_addr_o];
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        busy_mid;
    logic        clr_mid;
    logic        exp_req;
    logic [6:0]  exp_addr;
    logic [1:0]  exp_be;
    logic [23:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic bm, input logic cm, input logic er,
                     input logic [6:0] ea, input logic [1:0] eb, input logic [23:0] ed,
                     input logic [31:0] erd, input logic ee);
    vec_t v;
    v.name = n; v.we = w; v.addr = a; v.be = b; v.wdata = d; v.busy_mid = bm; v.clr_mid = cm;
    v.exp_req = er; v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ed; v.exp_rdata = erd;
    v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic run_txn(input vec_t v);
    int waitc;
    vec_t e;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = v.we; addr_i = v.addr; be_i = v.be; wdata_i = v.wdata;
    waitc = 0;
    @(negedge clk_i);
    while (!gnt_o && waitc < 50) begin
      @(negedge clk_i);
      waitc++;
    end
    chk({v.name, " gnt"}, {31'h0, gnt_o}, 32'h1);
    sb.push_back(v);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    if (v.busy_mid) engine_busy_i = 1'b1;
    if (v.clr_mid) err_clr_i = 1'b1;
    @(negedge clk_i);
    chk({v.name, " mem_req"}, {31'h0, mem_req_o}, {31'h0, v.exp_req});
    if (v.exp_req) begin
      chk({v.name, " mem_we"}, {31'h0, mem_we_o}, {31'h0, v.we});
      chk({v.name, " mem_addr"}, {25'h0, mem_addr_o}, {25'h0, v.exp_addr});
      chk({v.name, " mem_be"}, {30'h0, mem_be_o}, {30'h0, v.exp_be});
      if (v.we) chk({v.name, " mem_wdata"}, {8'h0, mem_wdata_o}, {8'h0, v.exp_wdata});
    end
    chk({v.name, " rvalid_early"}, {31'h0, rvalid_o}, 32'h0);
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
    @(negedge clk_i);
    chk({v.name, " rvalid"}, {31'h0, rvalid_o}, 32'h1);
    if (rvalid_o && sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, " rdata"}, rdata_o, e.exp_rdata);
      chk({e.name, " err"}, {31'h0, err_o}, {31'h0, e.exp_err});
    end
    @(posedge clk_i); #1;
    engine_busy_i = 1'b0;
    if (v.exp_err) begin
      err_clr_i = 1'b1;
      @(posedge clk_i); #1;
      err_clr_i = 1'b0;
      @(negedge clk_i);
      chk({v.name, " err_clr"}, {31'h0, err_o}, 32'h0);
    end
    $display("txn %s we=%0b addr=%h be=%h wdata=%h", v.name, v.we, v.addr, v.be, v.wdata);
  endtask

  initial begin
    //   name       we   addr          be    wdata          bm cm req addr  be     wdata      rdata          err
    add("wr_w4",   1, 32'h0000_0010, 4'hF, 32'h0123_0456, 0, 0, 1, 7'd4,   2'b11, 24'h123456, 32'h0,         0);
    add("rd_w4",   0, 32'h0000_0010, 4'hF, 32'h0,         0, 0, 1, 7'd4,   2'b11, 24'h0,      32'h0123_0456, 0);
    add("wr_w5",   1, 32'h0000_0014, 4'hF, 32'h0ABC_0123, 0, 0, 1, 7'd5,   2'b11, 24'hABC123, 32'h0,         0);
    add("rd_w5_bz",0, 32'h0000_0014, 4'hF, 32'h0,         1, 0, 1, 7'd5,   2'b11, 24'h0,      32'h0ABC_0123, 0);
    add("wr_hi_lo",1, 32'hFFE0_0018, 4'h3, 32'hFFFF_0777, 0, 0, 1, 7'd6,   2'b01, 24'hFFF777, 32'h0,         0);
    add("rd_w6",   0, 32'h0000_0018, 4'hF, 32'h0,         0, 0, 1, 7'd6,   2'b11, 24'h0,      32'h0000_0777, 0);
    add("wr_w127", 1, 32'h0000_01FC, 4'hC, 32'h07FF_0FFF, 0, 0, 1, 7'd127, 2'b10, 24'h7FFFFF, 32'h0,         0);
    add("rd_w127", 0, 32'h0000_01FC, 4'hF, 32'h0,         0, 0, 1, 7'd127, 2'b11, 24'h0,      32'h07FF_0000, 0);
    add("rd_w128", 0, 32'h0000_0200, 4'hF, 32'h0,         0, 1, 0, 7'd0,   2'b00, 24'h0,      32'h0,         1);
    add("wr_top",  1, 32'h001F_FFFC, 4'hF, 32'h0001_0001, 0, 0, 0, 7'd0,   2'b00, 24'h0,      32'h0,         1);
    add("wr_be0",  1, 32'h0000_0020, 4'h0, 32'h0,         0, 0, 1, 7'd8,   2'b00, 24'h0,      32'h0,         0);
`ifdef NTT_INTT_BRIDGE_RANGE_CHECK_EN
    add("wr_q_lo", 1, 32'h0000_0030, 4'h3, 32'h0000_0D01, 0, 0, 0, 7'd0,   2'b00, 24'h0,      32'h0,         1);
    add("wr_q_hi", 1, 32'h0000_0030, 4'hC, 32'h0000_0D01, 0, 0, 1, 7'd12,  2'b10, 24'h000D01, 32'h0,         0);
`else
    add("wr_q_raw",1, 32'h0000_0030, 4'h3, 32'h0000_0D01, 0, 0, 1, 7'd12,  2'b01, 24'h000D01, 32'h0,         0);
`endif

    // Reset state, with a pending request that must not be granted.
    req_i = 1'b1;
    #2;
    chk("rst gnt", {31'h0, gnt_o}, 32'h0);
    chk("rst rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("rst mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst err", {31'h0, err_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Grant held off while the engine is busy.
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF; engine_busy_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("busy gnt", {31'h0, gnt_o}, 32'h0);
      chk("busy mem_req", {31'h0, mem_req_o}, 32'h0);
      @(posedge clk_i); #1;
    end
    engine_busy_i = 1'b0;
    @(negedge clk_i);
    chk("busy release gnt", {31'h0, gnt_o}, 32'h1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    chk("busy mem_req", {31'h0, mem_req_o}, 32'h1);
    @(negedge clk_i);
    chk("busy rvalid", {31'h0, rvalid_o}, 32'h1);
    chk("busy rdata", rdata_o, 32'h0123_0456);
    $display("txn busy_hold read addr=00000010");

    // Reset in the ACCESS cycle of a read abandons it without a response.
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h14;
    @(negedge clk_i);
    chk("rstmid gnt", {31'h0, gnt_o}, 32'h1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    chk("rstmid mem_req pre", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk("rstmid mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rstmid rvalid", {31'h0, rvalid_o}, 32'h0);
    req_i = 1'b1;
    @(negedge clk_i);
    chk("rstmid gnt held", {31'h0, gnt_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("rstmid no rvalid", {31'h0, rvalid_o}, 32'h0);
    end
    $display("txn reset_abandon read addr=00000014");
    run_txn(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
